// File: rtl/mc_pkg.sv
// Shared definitions for the multicast branch serializer: branch count,
// direction encoding, FSM state type and a one-hot test.
package mc_pkg;

    localparam int unsigned NUM_BRANCH = 5;

    typedef logic [NUM_BRANCH-1:0] dir_t;

    localparam dir_t DIR_L = 5'b00001;
    localparam dir_t DIR_N = 5'b00010;
    localparam dir_t DIR_E = 5'b00100;
    localparam dir_t DIR_S = 5'b01000;
    localparam dir_t DIR_W = 5'b10000;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    function automatic logic is_one_hot(input dir_t d);
        return (d != '0) && ((d & (d - dir_t'(1))) == '0);
    endfunction

endpackage

// File: rtl/mc_pick_first.sv
// Lowest-set-bit priority encoder: one-hot select of the first requester.
module mc_pick_first
    import mc_pkg::*;
(
    input  logic [NUM_BRANCH-1:0] req,
    output logic [NUM_BRANCH-1:0] sel,
    output logic                  any
);

    // Two's-complement trick isolates the lowest set bit.
    assign sel = req & (~req + dir_t'(1));
    assign any = |req;

endmodule

// File: rtl/mc_branch_serializer.sv
// Captures up to five multicast branches from routing computation and issues
// them one per grant to the switch allocator, lowest slot first.
module mc_branch_serializer
    import mc_pkg::*;
#(
    parameter int unsigned DATASIZE = 30
) (
    input  logic                rc_clk,
    input  logic                rst_n,
    input  logic [DATASIZE-1:0] data_in1,
    input  logic [DATASIZE-1:0] data_in2,
    input  logic [DATASIZE-1:0] data_in3,
    input  logic [DATASIZE-1:0] data_in4,
    input  logic [DATASIZE-1:0] data_in5,
    input  logic [4:0]          direction_in1,
    input  logic [4:0]          direction_in2,
    input  logic [4:0]          direction_in3,
    input  logic [4:0]          direction_in4,
    input  logic [4:0]          direction_in5,
    output logic                rc_ready,
    output logic                sa_valid,
    output logic [4:0]          sa_req,
    output logic [DATASIZE-1:0] sa_data,
    input  logic                sa_grant,
    output logic                dir_err
);

    state_t                state, state_nxt;
    logic [DATASIZE-1:0]   din      [NUM_BRANCH];
    dir_t                  dir_in   [NUM_BRANCH];
    logic [DATASIZE-1:0]   slot_data[NUM_BRANCH];
    dir_t                  slot_dir [NUM_BRANCH];
    dir_t                  pend;
    dir_t                  sel;
    logic                  pend_any;
    dir_t                  cap_pend;
    logic                  cap_bad;
    logic                  set_valid;
    logic                  capture;
    logic                  fire;
    logic [DATASIZE-1:0]   pick_data;
    dir_t                  pick_dir;

    always_comb begin
        din[0] = data_in1;  dir_in[0] = direction_in1;
        din[1] = data_in2;  dir_in[1] = direction_in2;
        din[2] = data_in3;  dir_in[2] = direction_in3;
        din[3] = data_in4;  dir_in[3] = direction_in4;
        din[4] = data_in5;  dir_in[4] = direction_in5;
    end

    always_comb begin
        cap_pend  = '0;
        cap_bad   = 1'b0;
        set_valid = 1'b0;
        for (int unsigned k = 0; k < NUM_BRANCH; k++) begin
            cap_pend[k] = is_one_hot(dir_in[k]);
            if (dir_in[k] != '0) begin
                set_valid = 1'b1;
                if (!is_one_hot(dir_in[k]))
                    cap_bad = 1'b1;
            end
        end
    end

    mc_pick_first u_pick (
        .req (pend),
        .sel (sel),
        .any (pend_any)
    );

    always_comb begin
        pick_dir  = '0;
        pick_data = '0;
        for (int unsigned k = 0; k < NUM_BRANCH; k++) begin
            if (sel[k]) begin
                pick_dir  = pick_dir  | slot_dir[k];
                pick_data = pick_data | slot_data[k];
            end
        end
    end

    assign capture = (state == IDLE) && set_valid;
    assign fire    = sa_valid && sa_grant;

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (set_valid && (cap_pend != '0)) state_nxt = ISSUE;
            ISSUE: if (fire && ((pend & ~sel) == '0)) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        rc_ready = (state == IDLE);
        sa_valid = (state == ISSUE) && pend_any;
        sa_req   = sa_valid ? pick_dir  : '0;
        sa_data  = sa_valid ? pick_data : '0;
    end

    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= '0;
            dir_err <= 1'b0;
            for (int unsigned k = 0; k < NUM_BRANCH; k++) begin
                slot_data[k] <= '0;
                slot_dir[k]  <= '0;
            end
        end else if (capture) begin
            pend <= cap_pend;
            if (cap_bad) dir_err <= 1'b1;
            for (int unsigned k = 0; k < NUM_BRANCH; k++) begin
                slot_data[k] <= din[k];
                slot_dir[k]  <= dir_in[k];
            end
        end else if (fire) begin
            pend <= pend & ~sel;
        end
    end

endmodule

// File: tb/tb_mc_branch_serializer.sv
// Directed bench for mc_branch_serializer with a queue-based reference model.
module tb_mc_branch_serializer;

    localparam int unsigned DW = 30;

    typedef struct {
        logic [4:0]    dir;
        logic [DW-1:0] data;
    } br_t;

    logic          rc_clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] d_in [5];
    logic [4:0]    dr_in[5];
    logic          sa_grant;
    logic          rc_ready, sa_valid, dir_err;
    logic [4:0]    sa_req;
    logic [DW-1:0] sa_data;

    int errors = 0;
    int checks = 0;
    logic check_en = 1'b0;

    br_t  m_q[$];
    logic m_busy = 1'b0;
    logic m_err  = 1'b0;

    always #5 rc_clk = ~rc_clk;

    mc_branch_serializer #(.DATASIZE(DW)) dut (
        .rc_clk        (rc_clk),
        .rst_n         (rst_n),
        .data_in1      (d_in[0]),
        .data_in2      (d_in[1]),
        .data_in3      (d_in[2]),
        .data_in4      (d_in[3]),
        .data_in5      (d_in[4]),
        .direction_in1 (dr_in[0]),
        .direction_in2 (dr_in[1]),
        .direction_in3 (dr_in[2]),
        .direction_in4 (dr_in[3]),
        .direction_in5 (dr_in[4]),
        .rc_ready      (rc_ready),
        .sa_valid      (sa_valid),
        .sa_req        (sa_req),
        .sa_data       (sa_data),
        .sa_grant      (sa_grant),
        .dir_err       (dir_err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a set becomes a FIFO of its one-hot branches; each grant pops one.
    always @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q.delete();
            m_busy = 1'b0;
            m_err  = 1'b0;
        end else if (!m_busy) begin
            bit any_set = 1'b0;
            for (int k = 0; k < 5; k++) if (dr_in[k] != 5'd0) any_set = 1'b1;
            if (any_set) begin
                for (int k = 0; k < 5; k++) begin
                    if ($countones(dr_in[k]) == 1) m_q.push_back('{dir: dr_in[k], data: d_in[k]});
                    else if (dr_in[k] != 5'd0) m_err = 1'b1;
                end
                m_busy = (m_q.size() != 0);
            end
        end else if (sa_grant) begin
            void'(m_q.pop_front());
            m_busy = (m_q.size() != 0);
        end
    end

    always @(negedge rc_clk) begin
        if (check_en) begin
            chk("rc_ready", 64'(rc_ready), 64'(!m_busy));
            chk("sa_valid", 64'(sa_valid), 64'(m_busy));
            chk("sa_req",   64'(sa_req),   m_busy ? 64'(m_q[0].dir)  : 64'd0);
            chk("sa_data",  64'(sa_data),  m_busy ? 64'(m_q[0].data) : 64'd0);
            chk("dir_err",  64'(dir_err),  64'(m_err));
        end
    end

    task automatic tick();
        @(posedge rc_clk);
        #1;
    endtask

    task automatic clear_in();
        for (int k = 0; k < 5; k++) begin
            d_in[k]  = '0;
            dr_in[k] = '0;
        end
    endtask

    task automatic set_slot(input int k, input logic [4:0] dir, input logic [DW-1:0] data);
        dr_in[k] = dir;
        d_in[k]  = data;
    endtask

    task automatic chk_out(input string name, input logic [4:0] req, input logic [DW-1:0] data);
        chk({name, "_valid"}, 64'(sa_valid), 64'(req != 5'd0));
        chk({name, "_req"},   64'(sa_req),   64'(req));
        chk({name, "_data"},  64'(sa_data),  64'(data));
    endtask

    initial begin
        rst_n    = 1'b0;
        sa_grant = 1'b0;
        clear_in();
        tick(); tick();
        rst_n = 1'b1;
        check_en = 1'b1;

        // reset and idle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_ready", 64'(rc_ready), 64'd1);
            chk("idle_valid", 64'(sa_valid), 64'd0);
            chk("idle_err",   64'(dir_err),  64'd0);
        end

        // three branches, grant tied high
        sa_grant = 1'b1;
        set_slot(0, 5'b00010, 30'h1);
        set_slot(2, 5'b00100, 30'h3);
        set_slot(4, 5'b10000, 30'h5);
        tick();
        clear_in();
        chk_out("b3_1", 5'b00010, 30'h1);
        chk("b3_busy", 64'(rc_ready), 64'd0);
        tick(); chk_out("b3_2", 5'b00100, 30'h3);
        tick(); chk_out("b3_3", 5'b10000, 30'h5);
        tick(); chk_out("b3_end", 5'b00000, 30'h0);
        chk("b3_ready", 64'(rc_ready), 64'd1);

        // stall for six cycles then grant
        sa_grant = 1'b0;
        set_slot(1, 5'b01000, 30'h22);
        tick();
        clear_in();
        for (int i = 0; i < 6; i++) begin
            chk_out("stall", 5'b01000, 30'h22);
            tick();
        end
        sa_grant = 1'b1;
        chk_out("stall_7", 5'b01000, 30'h22);
        tick();
        chk_out("stall_end", 5'b00000, 30'h0);

        // bad direction in slot 1
        set_slot(0, 5'b00011, 30'hA);
        set_slot(1, 5'b00001, 30'hB);
        tick();
        clear_in();
        chk_out("bad_l", 5'b00001, 30'hB);
        chk("bad_err", 64'(dir_err), 64'd1);
        tick();
        chk_out("bad_end", 5'b00000, 30'h0);
        set_slot(3, 5'b00100, 30'h44);
        tick();
        clear_in();
        chk_out("bad_next", 5'b00100, 30'h44);
        tick();
        chk("bad_sticky", 64'(dir_err), 64'd1);

        // inputs changed while busy are not captured
        sa_grant = 1'b0;
        set_slot(0, 5'b00001, 30'h11);
        set_slot(1, 5'b00010, 30'h12);
        tick();
        set_slot(0, 5'b10000, 30'h77);
        set_slot(1, 5'b00000, 30'h99);
        set_slot(2, 5'b01000, 30'h78);
        chk_out("busy_1", 5'b00001, 30'h11);
        tick(); tick();
        sa_grant = 1'b1;
        chk_out("busy_1h", 5'b00001, 30'h11);
        tick(); chk_out("busy_2", 5'b00010, 30'h12);
        tick(); chk("busy_ready", 64'(rc_ready), 64'd1);
        tick(); chk_out("busy_new1", 5'b10000, 30'h77);
        clear_in();
        tick(); chk_out("busy_new2", 5'b01000, 30'h78);
        tick(); chk_out("busy_end", 5'b00000, 30'h0);

        // reset after the first of four grants
        for (int k = 0; k < 4; k++) set_slot(k, 5'(1 << k), 30'h101 + 30'(k));
        tick();
        clear_in();
        chk_out("rst_1", 5'b00001, 30'h101);
        tick();
        chk_out("rst_2", 5'b00010, 30'h102);
        rst_n = 1'b0;
        #1;
        chk_out("rst_now", 5'b00000, 30'h0);
        chk("rst_ready", 64'(rc_ready), 64'd1);
        chk("rst_err",   64'(dir_err),  64'd0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_out("rst_after", 5'b00000, 30'h0);
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
